jtpocket_bridge_host: RTL and testbench

JTPOCKET_BRIDGE_HOST -- requirements
Module: jtpocket_bridge_host

---
 rtl/jtpocket_bridge_host_if.sv | 22 ++
 rtl/jtpocket_bridge_host.sv | 108 ++++++++++
 tb/tb_jtpocket_bridge_host.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/jtpocket_bridge_host_if.sv
// jtpocket_bridge_host_if: command handshake, read result and bridge SPI pins of the bridge host.
interface jtpocket_bridge_host_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_wr;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [31:0] rdata;
   logic        done;
   logic        spiclk;
   logic        spiss;
   logic        spimosi;
   logic        spimiso;
   modport master (
      output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, spimiso,
      input  cmd_ready, rdata, done, spiclk, spiss, spimosi
   );
   modport slave (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, spimiso,
      output cmd_ready, rdata, done, spiclk, spiss, spimosi
   );
endinterface

// File: rtl/jtpocket_bridge_host.sv
// jtpocket_bridge_host: SPI mode-0 host framing 32-bit bridge reads and writes, MSB first.
module jtpocket_bridge_host #(
   parameter int CLKDIV = 4,
   parameter int GAP    = 8
) (
   input logic                   clk,
   input logic                   rst,
   jtpocket_bridge_host_if.slave bus
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SETUP = 3'd1;
   localparam logic [2:0] SHIFT = 3'd2;
   localparam logic [2:0] TURN  = 3'd3;
   localparam logic [2:0] READ  = 3'd4;
   localparam logic [2:0] HOLD  = 3'd5;
   localparam logic [2:0] GAPW  = 3'd6;
   localparam logic [15:0] DIV_END = 16'(CLKDIV - 1);
   localparam logic [15:0] GAP_END = 16'(GAP - 1);
   logic [2:0]  state;
   logic [15:0] cnt;
   logic [6:0]  bits;
   logic [6:0]  nbits;
   logic [71:0] tx;
   logic [31:0] rx;
   logic [31:0] rdata;
   logic [1:0]  miso_s;
   logic        wr;
   logic        ready;
   logic        ss;
   logic        sck;
   logic        done;
   assign nbits         = bits + 7'd1;
   assign bus.cmd_ready = ready;
   assign bus.rdata     = rdata;
   assign bus.done      = done;
   assign bus.spiclk    = sck;
   assign bus.spiss     = ss;
   // Only header/data bits reach the pin; turnaround, read phase and idle drive zero.
   assign bus.spimosi   = (state == SETUP || state == SHIFT) && tx[71];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         bits   <= '0;
         tx     <= '0;
         rx     <= '0;
         rdata  <= '0;
         miso_s <= '0;
         wr     <= 1'b0;
         ready  <= 1'b0;
         ss     <= 1'b1;
         sck    <= 1'b0;
         done   <= 1'b0;
      end else begin
         done   <= 1'b0;
         miso_s <= {miso_s[0], bus.spimiso};
         case (state)
            IDLE:
               if (bus.cmd_valid && ready) begin
                  state <= SETUP;
                  ready <= 1'b0;
                  ss    <= 1'b0;
                  cnt   <= '0;
                  bits  <= '0;
                  wr    <= bus.cmd_wr;
                  tx    <= {bus.cmd_wr ? 8'h5A : 8'hA5, bus.cmd_addr, bus.cmd_wr ? bus.cmd_wdata : 32'd0};
               end else ready <= 1'b1;
            SETUP:
               if (cnt == DIV_END) begin
                  cnt   <= '0;
                  state <= SHIFT;
               end else cnt <= cnt + 16'd1;
            SHIFT, TURN, READ:
               if (cnt != DIV_END) cnt <= cnt + 16'd1;
               else begin
                  cnt <= '0;
                  sck <= !sck;
                  // Rising edge: the synchronized MISO bit is taken here.
                  if (!sck && state == READ) rx <= {rx[30:0], miso_s[1]};
                  // Falling edge: a pulse is complete, advance MOSI and the phase.
                  if (sck) begin
                     bits <= nbits;
                     tx   <= {tx[70:0], 1'b0};
                     if (state == SHIFT && nbits == (wr ? 7'd72 : 7'd40)) state <= wr ? HOLD : TURN;
                     if (state == TURN && nbits == 7'd48) state <= READ;
                     if (state == READ && nbits == 7'd80) begin
                        state <= HOLD;
                        rdata <= rx;
                     end
                  end
               end
            HOLD:
               if (cnt == DIV_END) begin
                  cnt   <= '0;
                  state <= GAPW;
                  ss    <= 1'b1;
                  done  <= 1'b1;
               end else cnt <= cnt + 16'd1;
            GAPW:
               if (cnt == GAP_END) begin
                  cnt   <= '0;
                  state <= IDLE;
                  ready <= 1'b1;
               end else cnt <= cnt + 16'd1;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_jtpocket_bridge_host.sv
// tb_jtpocket_bridge_host: vector table and random frames checked against a frame-level model,
// plus back-to-back, mid-frame reset and clock-divider corner cases.
module tb_jtpocket_bridge_host;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jtpocket_bridge_host_if a();
   jtpocket_bridge_host_if b();
   jtpocket_bridge_host_if c();
   jtpocket_bridge_host #(.CLKDIV(4),   .GAP(8)) dut_a (.clk(clk), .rst(rst), .bus(a));
   jtpocket_bridge_host #(.CLKDIV(2),   .GAP(8)) dut_b (.clk(clk), .rst(rst), .bus(b));
   jtpocket_bridge_host #(.CLKDIV(255), .GAP(8)) dut_c (.clk(clk), .rst(rst), .bus(c));

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mval;
      int          pulses;
      logic [31:0] rd;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [31:0] core_val = '0;
   int n_rise = 0, n_fall = 0, ss_low = 0, done_n = 0, mosi_bad = 0;
   int hi_run = 0, rdy_run = 0, gap_last = 0, rdy_last = 0, n_ss_fall = 0;
   logic [79:0] mosi_seq = '0;
   logic [31:0] rd_at_done = '0;
   logic p_clk = 1'b0, p_mosi = 1'b0, p_ss = 1'b1;

   // Bridge-core model and frame monitor for the CLKDIV=4 instance.
   always @(negedge clk) begin
      int idx;
      if (a.cmd_valid && a.cmd_ready) begin
         n_rise = 0; n_fall = 0; ss_low = 0; done_n = 0; mosi_bad = 0; mosi_seq = '0;
      end
      if (!a.spiss) ss_low++;
      if (a.spiclk && !p_clk) begin
         mosi_seq = {mosi_seq[78:0], a.spimosi};
         n_rise++;
      end
      if (!a.spiclk && p_clk) n_fall++;
      if ((a.spiclk && p_clk && a.spimosi != p_mosi) || (a.spiss && a.spimosi)) mosi_bad++;
      if (a.done) begin
         done_n++;
         rd_at_done = a.rdata;
      end
      if (!a.spiss && p_ss) begin
         gap_last = hi_run; rdy_last = rdy_run; hi_run = 0; rdy_run = 0; n_ss_fall++;
      end
      if (a.spiss) hi_run++;
      if (a.cmd_ready) rdy_run++;
      idx = 79 - n_fall;
      a.spimiso = (n_fall >= 48 && n_fall < 80) ? core_val[idx[4:0]] : 1'($urandom);
      p_clk = a.spiclk; p_mosi = a.spimosi; p_ss = a.spiss;
   end

   int b_lr = 0, b_pmin = 1 << 30, b_pmax = 0, b_ss = 0, b_dn = 0;
   int c_lr = 0, c_pmin = 1 << 30, c_pmax = 0, c_ss = 0, c_dn = 0;
   logic b_pc = 1'b0, c_pc = 1'b0;
   always @(negedge clk) begin
      if (b.spiclk && !b_pc) begin
         if (b_lr > 0) begin
            if (cyc - b_lr < b_pmin) b_pmin = cyc - b_lr;
            if (cyc - b_lr > b_pmax) b_pmax = cyc - b_lr;
         end
         b_lr = cyc;
      end
      if (!b.spiss) b_ss++;
      if (b.done) b_dn++;
      b_pc = b.spiclk;
      if (c.spiclk && !c_pc) begin
         if (c_lr > 0) begin
            if (cyc - c_lr < c_pmin) c_pmin = cyc - c_lr;
            if (cyc - c_lr > c_pmax) c_pmax = cyc - c_lr;
         end
         c_lr = cyc;
      end
      if (!c.spiss) c_ss++;
      if (c.done) c_dn++;
      c_pc = c.spiclk;
   end

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   // Issue one command, scramble cmd_* right after the handshake, then compare the frame.
   task automatic run_frame(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] mv, input int pulses, input logic [31:0] rd);
      int t;
      logic [79:0] exp_seq;
      core_val = mv;
      @(posedge clk); #1;
      a.cmd_valid = 1'b1; a.cmd_wr = wr; a.cmd_addr = addr; a.cmd_wdata = wd;
      t = 0;
      while (!a.cmd_ready && t < 100) begin @(posedge clk); #1; t++; end
      @(posedge clk); #1;
      a.cmd_valid = 1'b0; a.cmd_wr = ~wr; a.cmd_addr = $urandom; a.cmd_wdata = $urandom;
      t = 0;
      while (!a.cmd_ready && t < 2000) begin @(negedge clk); t++; end
      exp_seq = wr ? {8'h00, 8'h5A, addr, wd} : {8'hA5, addr, 8'h00, 32'h0};
      chk("mosi",    wr ? mosi_seq : {mosi_seq[79:32], 32'h0}, exp_seq);
      chk("pulses",  80'(n_rise), 80'(pulses));
      chk("ss_low",  80'(ss_low), 80'((2 * pulses + 2) * 4));
      chk("done",    80'(done_n), 80'd1);
      chk("rdata@done", 80'(rd_at_done), 80'(rd));
      chk("mode0",   80'(mosi_bad), 80'd0);
   endtask

   initial begin
      vec_t tbl[4];
      logic        wr;
      logic [31:0] addr, wd, mv, exp_rd;
      int t, s;
      tbl[0] = '{1'b1, 32'hF800_0000, 32'h1234_5678, 32'h0000_0000, 72, 32'h0000_0000};
      tbl[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 80, 32'hDEAD_BEEF};
      tbl[2] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 72, 32'hDEAD_BEEF};
      tbl[3] = '{1'b0, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 80, 32'h0000_0001};
      a.cmd_valid = 1'b0; a.cmd_wr = 1'b0; a.cmd_addr = '0; a.cmd_wdata = '0;
      b.cmd_valid = 1'b0; b.cmd_wr = 1'b0; b.cmd_addr = '0; b.cmd_wdata = '0; b.spimiso = 1'b0;
      c.cmd_valid = 1'b0; c.cmd_wr = 1'b0; c.cmd_addr = '0; c.cmd_wdata = '0; c.spimiso = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_ready", 80'(a.cmd_ready), 80'd0);
      chk("rst_spiss", 80'(a.spiss),     80'd1);
      chk("rst_spiclk", 80'(a.spiclk),   80'd0);
      chk("rst_mosi",  80'(a.spimosi),   80'd0);
      chk("rst_done",  80'(a.done),      80'd0);
      chk("rst_rdata", 80'(a.rdata),     80'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rel_ready", 80'(a.cmd_ready), 80'd1);

      foreach (tbl[i]) run_frame(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].mval, tbl[i].pulses, tbl[i].rd);

      exp_rd = tbl[3].rd;
      for (int i = 0; i < 6; i++) begin
         wr = 1'($urandom); addr = $urandom; wd = $urandom; mv = $urandom;
         if (!wr) exp_rd = mv;
         run_frame(wr, addr, wd, mv, wr ? 72 : 80, exp_rd);
      end

      // Back-to-back: cmd_valid held across two frames.
      @(posedge clk); #1;
      a.cmd_valid = 1'b1; a.cmd_wr = 1'b1; a.cmd_addr = $urandom; a.cmd_wdata = $urandom;
      s = n_ss_fall; t = 0;
      while (n_ss_fall < s + 2 && t < 3000) begin @(negedge clk); t++; end
      @(posedge clk); #1;
      a.cmd_valid = 1'b0;
      t = 0;
      while (!a.cmd_ready && t < 2000) begin @(negedge clk); t++; end
      chk("b2b_frames", 80'(n_ss_fall - s), 80'd2);
      chk("b2b_gap",    80'(gap_last >= 8), 80'd1);
      chk("b2b_ready",  80'(rdy_last), 80'd1);
      chk("b2b_done",   80'(done_n), 80'd1);

      // Reset at pulse 30 of a read.
      core_val = 32'hCAFE_F00D;
      @(posedge clk); #1;
      a.cmd_valid = 1'b1; a.cmd_wr = 1'b0; a.cmd_addr = $urandom;
      t = 0;
      while (!a.cmd_ready && t < 100) begin @(posedge clk); #1; t++; end
      @(posedge clk); #1;
      a.cmd_valid = 1'b0;
      t = 0;
      while (n_rise < 30 && t < 1000) begin @(negedge clk); t++; end
      chk("abort_at30", 80'(n_rise), 80'd30);
      #1 rst = 1'b1;
      #1;
      chk("abort_spiss",  80'(a.spiss),  80'd1);
      chk("abort_spiclk", 80'(a.spiclk), 80'd0);
      chk("abort_mosi",   80'(a.spimosi), 80'd0);
      repeat (3) @(negedge clk);
      chk("abort_ready",  80'(a.cmd_ready), 80'd0);
      chk("abort_rdata0", 80'(a.rdata), 80'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_rel_ready", 80'(a.cmd_ready), 80'd1);
      repeat (20) @(negedge clk);
      chk("abort_no_done", 80'(done_n), 80'd0);
      chk("abort_rdata",   80'(a.rdata), 80'd0);

      // Clock divider extremes, both frames in parallel.
      @(posedge clk); #1;
      b.cmd_valid = 1'b1; b.cmd_wr = 1'b1; b.cmd_addr = $urandom; b.cmd_wdata = $urandom;
      c.cmd_valid = 1'b1; c.cmd_wr = 1'b1; c.cmd_addr = $urandom; c.cmd_wdata = $urandom;
      @(posedge clk); #1;
      b.cmd_valid = 1'b0; c.cmd_valid = 1'b0;
      t = 0;
      while ((b_dn == 0 || c_dn == 0) && t < 40000) begin @(negedge clk); t++; end
      chk("div2_pmin",   80'(b_pmin), 80'd4);
      chk("div2_pmax",   80'(b_pmax), 80'd4);
      chk("div2_ss",     80'(b_ss),   80'((2 * 72 + 2) * 2));
      chk("div255_pmin", 80'(c_pmin), 80'd510);
      chk("div255_pmax", 80'(c_pmax), 80'd510);
      chk("div255_ss",   80'(c_ss),   80'((2 * 72 + 2) * 255));
      chk("div_done",    80'(b_dn + c_dn), 80'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
